// File: rtl/axistream_upsize.sv
// Narrow-to-wide AXI-Stream packer: RATIO narrow beats (or fewer on tlast) form one wide beat.
// Optional macro AXISTREAM_UPSIZE_ZERO_PAD_EN zeroes the unpopulated lanes of each wide word.
module axistream_upsize #(
   parameter int DATA_WIDTH = 8,
   parameter int RATIO      = 4,
   parameter int CNT_WIDTH  = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        src_tvalid,
   output logic                        src_tready,
   input  logic [DATA_WIDTH-1:0]       src_tdata,
   input  logic                        src_tlast,
   output logic                        dest_tvalid,
   input  logic                        dest_tready,
   output logic [DATA_WIDTH*RATIO-1:0] dest_tdata,
   output logic                        dest_tlast,
   output logic [CNT_WIDTH-1:0]        dest_tcnt
);

   localparam int WIDE_W = DATA_WIDTH * RATIO;

   logic [CNT_WIDTH-1:0] lcnt;
   logic [WIDE_W-1:0]    asm_data;
   logic [WIDE_W-1:0]    merged;
   logic [WIDE_W-1:0]    out_data;
   logic                 out_last;
   logic [CNT_WIDTH-1:0] out_cnt;
   logic                 out_valid;
   logic                 acc;
   logic                 drn;
   logic                 completing;

   // The dest_tready -> src_tready path is combinational; the downstream timing-break stage absorbs it.
   assign src_tready  = !rst && (!out_valid || dest_tready);
   assign dest_tvalid = out_valid && !rst;
   assign acc         = src_tvalid && src_tready;
   assign drn         = dest_tvalid && dest_tready;
   assign completing  = (lcnt == CNT_WIDTH'(RATIO - 1)) || src_tlast;

   // Stage 0: merge the incoming narrow beat into its lane of the assembly word
   always_comb begin
      merged = asm_data;
      for (int i = 0; i < RATIO; i++) begin
         if (CNT_WIDTH'(i) == lcnt) begin
            merged[i*DATA_WIDTH +: DATA_WIDTH] = src_tdata;
         end
`ifdef AXISTREAM_UPSIZE_ZERO_PAD_EN
         else if (CNT_WIDTH'(i) > lcnt) begin
            merged[i*DATA_WIDTH +: DATA_WIDTH] = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lcnt <= '0;
      end else if (acc) begin
         lcnt <= completing ? '0 : lcnt + 1'b1;
      end
   end

   // Stage 1: output register, reloadable in the same cycle it drains
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_cnt   <= '0;
      end else if (acc && completing) begin
         out_valid <= 1'b1;
         out_last  <= src_tlast;
         out_cnt   <= lcnt + 1'b1;
      end else if (drn) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (acc) begin
         asm_data <= merged;
      end
      if (acc && completing) begin
         out_data <= merged;
      end
   end

   assign dest_tdata = out_data;
   assign dest_tlast = out_last;
   assign dest_tcnt  = out_cnt;

   lcnt_in_range: assert property (@(posedge clk) disable iff (rst) lcnt < CNT_WIDTH'(RATIO));
   cnt_nonzero:   assert property (@(posedge clk) disable iff (rst) dest_tvalid |-> (dest_tcnt != '0));

endmodule

// File: tb/tb_axistream_upsize.sv
// Directed bench for axistream_upsize (8-bit lanes, RATIO=4) with a packing scoreboard.
module tb_axistream_upsize;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        src_tvalid = 1'b0;
   logic        src_tready;
   logic [7:0]  src_tdata = '0;
   logic        src_tlast = 1'b0;
   logic        dest_tvalid;
   logic        dest_tready = 1'b0;
   logic [31:0] dest_tdata;
   logic        dest_tlast;
   logic [2:0]  dest_tcnt;

   axistream_upsize #(.DATA_WIDTH(8), .RATIO(4), .CNT_WIDTH(3)) dut (
      .clk(clk), .rst(rst),
      .src_tvalid(src_tvalid), .src_tready(src_tready), .src_tdata(src_tdata), .src_tlast(src_tlast),
      .dest_tvalid(dest_tvalid), .dest_tready(dest_tready), .dest_tdata(dest_tdata),
      .dest_tlast(dest_tlast), .dest_tcnt(dest_tcnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic [2:0]  cnt;
   } word_t;

   int          total = 0;
   int          bad = 0;
   word_t       exp_q[$];
   logic [31:0] m_word = '0;
   int          m_cnt = 0;
   int          acc_n = 0;
   bit          last_acc = 0;
   bit          hold = 0;
   logic [31:0] hold_data;
   logic        hold_last;
   logic [2:0]  hold_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [2:0] cnt);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) if (i < int'(cnt)) m[i*8 +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic drive(input bit v, input logic [7:0] d, input bit l, input bit r);
      src_tvalid  = v;
      src_tdata   = d;
      src_tlast   = l;
      dest_tready = r;
      #1;
   endtask

   // Record handshakes of the current cycle against the model, then cross the clock edge.
   task automatic adv();
      word_t e;
      if (hold && !rst) begin
         chk("stable_data", dest_tdata, hold_data);
         chk("stable_last", {31'd0, dest_tlast}, {31'd0, hold_last});
         chk("stable_cnt", {29'd0, dest_tcnt}, {29'd0, hold_cnt});
      end
      hold = dest_tvalid && !dest_tready && !rst;
      hold_data = dest_tdata;
      hold_last = dest_tlast;
      hold_cnt  = dest_tcnt;
      if (dest_tvalid && dest_tready) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_word", dest_tdata, 32'hxxxxxxxx);
         end else begin
            e = exp_q.pop_front();
            chk("sb_cnt", {29'd0, dest_tcnt}, {29'd0, e.cnt});
            chk("sb_last", {31'd0, dest_tlast}, {31'd0, e.last});
            chk("sb_data", dest_tdata & lane_mask(e.cnt), e.data & lane_mask(e.cnt));
         end
      end
      last_acc = src_tvalid && src_tready;
      if (last_acc) begin
         acc_n++;
         m_word[m_cnt*8 +: 8] = src_tdata;
         if (m_cnt == 3 || src_tlast) begin
            e.data = m_word;
            e.last = src_tlast;
            e.cnt  = 3'(m_cnt + 1);
            exp_q.push_back(e);
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
      if (rst) begin
         exp_q.delete();
         m_cnt = 0;
         hold = 0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit          v;
      logic [7:0]  d;
      bit          l;
      bit          all_ready;
      int          start_n;

      // reset
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      chk("rst_dest_tvalid", {31'd0, dest_tvalid}, 32'd0);
      chk("rst_src_tready", {31'd0, src_tready}, 32'd0);
      adv();
      adv();
      chk("rst_dest_tcnt", {29'd0, dest_tcnt}, 32'd0);
      chk("rst_dest_tlast", {31'd0, dest_tlast}, 32'd0);
      rst = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      chk("post_rst_src_tready", {31'd0, src_tready}, 32'd1);
      chk("post_rst_dest_tvalid", {31'd0, dest_tvalid}, 32'd0);

      // full word
      drive(1'b1, 8'h11, 1'b0, 1'b1); adv();
      drive(1'b1, 8'h22, 1'b0, 1'b1); adv();
      drive(1'b1, 8'h33, 1'b0, 1'b1); adv();
      drive(1'b1, 8'h44, 1'b1, 1'b1);
      chk("full_no_early_valid", {31'd0, dest_tvalid}, 32'd0);
      adv();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      chk("full_valid", {31'd0, dest_tvalid}, 32'd1);
      chk("full_data", dest_tdata, 32'h44332211);
      chk("full_cnt", {29'd0, dest_tcnt}, 32'd4);
      chk("full_last", {31'd0, dest_tlast}, 32'd1);
      adv();
      chk("full_valid_one_cycle", {31'd0, dest_tvalid}, 32'd0);

      // early tlast, then a fresh packet from lane 0
      drive(1'b1, 8'hAA, 1'b0, 1'b1); adv();
      drive(1'b1, 8'hBB, 1'b1, 1'b1); adv();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      chk("early_cnt", {29'd0, dest_tcnt}, 32'd2);
      chk("early_last", {31'd0, dest_tlast}, 32'd1);
      chk("early_low_half", {16'd0, dest_tdata[15:0]}, 32'h0000BBAA);
`ifdef AXISTREAM_UPSIZE_ZERO_PAD_EN
      chk("early_zero_pad", dest_tdata, 32'h0000BBAA);
`endif
      adv();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 8'(i), i == 4, 1'b1);
         adv();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      chk("next_pkt_data", dest_tdata, 32'h04030201);
      chk("next_pkt_cnt", {29'd0, dest_tcnt}, 32'd4);
      adv();

      // backpressure
      drive(1'b1, 8'h55, 1'b0, 1'b1); adv();
      drive(1'b1, 8'h66, 1'b0, 1'b1); adv();
      drive(1'b1, 8'h77, 1'b0, 1'b1); adv();
      drive(1'b1, 8'h88, 1'b0, 1'b1); adv();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'h99, 1'b0, 1'b0);
         chk("bp_src_tready_low", {31'd0, src_tready}, 32'd0);
         chk("bp_dest_valid", {31'd0, dest_tvalid}, 32'd1);
         chk("bp_data", dest_tdata, 32'h88776655);
         adv();
      end
      drive(1'b1, 8'h99, 1'b0, 1'b1);
      chk("bp_release_src_tready", {31'd0, src_tready}, 32'd1);
      adv();
      drive(1'b1, 8'h9A, 1'b0, 1'b1); adv();
      drive(1'b1, 8'h9B, 1'b0, 1'b1); adv();
      drive(1'b1, 8'h9C, 1'b1, 1'b1); adv();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      chk("bp_next_data", dest_tdata, 32'h9C9B9A99);
      chk("bp_next_last", {31'd0, dest_tlast}, 32'd1);
      adv();

      // streaming: 64 bytes, tlast every 10th
      all_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         drive(1'b1, 8'($urandom_range(0, 255)), (i % 10) == 9, 1'b1);
         if (!src_tready) all_ready = 1'b0;
         adv();
      end
      chk("stream_src_tready_never_low", {31'd0, all_ready}, 32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b1); adv();
      chk("stream_sb_empty", exp_q.size(), 32'd0);

      // reset mid-packet
      drive(1'b1, 8'h01, 1'b0, 1'b1); adv();
      drive(1'b1, 8'h02, 1'b0, 1'b1); adv();
      rst = 1'b1;
      drive(1'b1, 8'h03, 1'b0, 1'b1);
      chk("midrst_dest_tvalid", {31'd0, dest_tvalid}, 32'd0);
      chk("midrst_src_tready", {31'd0, src_tready}, 32'd0);
      adv();
      rst = 1'b0;
      drive(1'b1, 8'h10, 1'b0, 1'b1); adv();
      drive(1'b1, 8'h20, 1'b0, 1'b1); adv();
      drive(1'b1, 8'h30, 1'b0, 1'b1); adv();
      drive(1'b1, 8'h40, 1'b0, 1'b1); adv();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      chk("midrst_data", dest_tdata, 32'h40302010);
      chk("midrst_cnt", {29'd0, dest_tcnt}, 32'd4);
      adv();

      // random valid/ready, 1000 accepted beats, bounded cycle budget
      start_n = acc_n;
      v = 1'b0; d = 8'h00; l = 1'b0;
      for (int c = 0; c < 8000 && (acc_n - start_n) < 1000; c++) begin
         if (!v || last_acc) begin
            v = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            l = ($urandom_range(0, 4) == 0);
         end
         last_acc = 1'b0;
         drive(v, d, l, 1'($urandom_range(0, 1)));
         adv();
      end
      chk("rand_beats_accepted", acc_n - start_n, 32'd1000);
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 8'h00, 1'b0, 1'b1);
         adv();
      end
      chk("rand_sb_drained", exp_q.size(), 32'(m_cnt == 0 ? 0 : 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
